// File: rtl/sdram_mp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_mp_pkg
//  Description : Shared types for the multi-port SDRAM burst master.
//                Holds the transaction FSM state encoding, the operation type
//                and a helper that derives the byte-enable width from the
//                data width.
//  Revision    : 1.0 - initial release
// ============================================================================
package sdram_mp_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_CMD   = 3'd1,
        RD_DATA  = 3'd2,
        WR_BURST = 3'd3,
        DONE     = 3'd4
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // One byte-enable bit per byte lane.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_mp_burst_master_if.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_mp_burst_master_if
//  Description : Bundle of the client-side request/data signals and the
//                Avalon-MM master signals of the multi-port burst master.
//                Clock and reset are not part of the bundle.
//  Ports       : master - view of the burst master (drives grant/done/rd_*,
//                         wr_data_ack and the avm_* command signals)
//                slave  - view of the environment (clients + SDRAM controller)
//  Revision    : 1.0 - initial release
// ============================================================================
interface sdram_mp_burst_master_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 32,
    parameter int BURST_W   = 4
);
    import sdram_mp_pkg::*;

    localparam int BE_W = be_width(DATA_W);

    // Client side
    logic [NUM_PORTS-1:0]         req_read;
    logic [NUM_PORTS-1:0]         req_write;
    logic [NUM_PORTS*ADDR_W-1:0]  req_addr;
    logic [NUM_PORTS*BURST_W-1:0] req_burst;
    logic [NUM_PORTS*BE_W-1:0]    req_byteen;
    logic [NUM_PORTS*DATA_W-1:0]  wr_data;
    logic [NUM_PORTS-1:0]         wr_data_ack;
    logic [DATA_W-1:0]            rd_data;
    logic [NUM_PORTS-1:0]         rd_valid;
    logic [NUM_PORTS-1:0]         grant;
    logic [NUM_PORTS-1:0]         done;

    // Avalon-MM master side
    logic [ADDR_W-1:0]            avm_address;
    logic                         avm_read;
    logic                         avm_write;
    logic [BURST_W-1:0]           avm_burstcount;
    logic [BE_W-1:0]              avm_byteenable;
    logic [DATA_W-1:0]            avm_writedata;
    logic                         avm_waitrequest;
    logic [DATA_W-1:0]            avm_readdata;
    logic                         avm_readdatavalid;

    modport master (
        input  req_read, req_write, req_addr, req_burst, req_byteen, wr_data,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output wr_data_ack, rd_data, rd_valid, grant, done,
        output avm_address, avm_read, avm_write, avm_burstcount,
        output avm_byteenable, avm_writedata
    );

    modport slave (
        output req_read, req_write, req_addr, req_burst, req_byteen, wr_data,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  wr_data_ack, rd_data, rd_valid, grant, done,
        input  avm_address, avm_read, avm_write, avm_burstcount,
        input  avm_byteenable, avm_writedata
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin arbiter. Produces a one-hot grant for the first
//                requester found after the most recently served port. The
//                pointer only moves when update is pulsed, and then records
//                the port named by the one-hot owner vector.
//  Ports       : Clk, Reset - clock, asynchronous active-high reset
//                req        - request vector
//                update     - advance pointer to owner (one cycle pulse)
//                owner      - one-hot port that just completed service
//                gnt        - one-hot combinational grant
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 2
) (
    input  wire         Clk,
    input  wire         Reset,
    input  wire [N-1:0] req,
    input  wire         update,
    input  wire [N-1:0] owner,
    output logic [N-1:0] gnt
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    logic [IDX_W-1:0] r_last;
    logic [IDX_W-1:0] w_owner_idx;

    always_comb begin
        w_owner_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (owner[i]) begin
                w_owner_idx = IDX_W'(i);
            end
        end
    end

    // Reset points at the highest port so that port 0 is searched first.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_last <= IDX_W'(N - 1);
        end else if (update) begin
            r_last <= w_owner_idx;
        end
    end

    // Search last+1, last+2, ... modulo N; first hit wins.
    always_comb begin
        logic v_found;
        int   v_idx;
        gnt     = '0;
        v_found = 1'b0;
        v_idx   = 0;
        for (int k = 1; k <= N; k++) begin
            v_idx = int'(r_last) + k;
            if (v_idx >= N) begin
                v_idx = v_idx - N;
            end
            for (int i = 0; i < N; i++) begin
                if ((i == v_idx) && !v_found && req[i]) begin
                    gnt[i]  = 1'b1;
                    v_found = 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_mp_burst_master.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_mp_burst_master
//  Description : Multi-port burst-capable Avalon-MM master. NUM_PORTS clients
//                share one SDRAM controller slave port. One transaction of
//                1..MAX_BURST words runs at a time; ports are served
//                round-robin. Write words are pulled from the granted client
//                with wr_data_ack, read words are steered back with rd_valid.
//  Ports       : Clk, Reset - clock, asynchronous active-high reset
//                bus        - sdram_mp_burst_master_if.master:
//                  req_read/req_write/req_addr/req_burst/req_byteen/wr_data
//                             per-port requests and write data (in)
//                  wr_data_ack/rd_data/rd_valid/grant/done  client feedback
//                  avm_*      Avalon-MM master signals
//  Revision    : 1.0 - initial release
// ============================================================================
module sdram_mp_burst_master
    import sdram_mp_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 32,
    parameter int BURST_W   = 4
) (
    input  wire                        Clk,
    input  wire                        Reset,
    sdram_mp_burst_master_if.master    bus
);

    localparam int BE_W = be_width(DATA_W);

    // ------------------------------------------------------------------
    // State and latched transaction attributes
    // ------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [NUM_PORTS-1:0]   r_grant;
    logic [ADDR_W-1:0]      r_addr;
    logic [BURST_W-1:0]     r_burst;
    logic [BE_W-1:0]        r_byteen;
    logic [BURST_W-1:0]     r_cnt;
    logic [DATA_W-1:0]      r_rd_data;
    logic [NUM_PORTS-1:0]   r_rd_valid;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [NUM_PORTS-1:0]   w_arb_req;
    logic [NUM_PORTS-1:0]   w_arb_gnt;
    logic                   w_arb_update;

    assign w_arb_req    = bus.req_read | bus.req_write;
    assign w_arb_update = (r_state == DONE);

    rr_arbiter #(
        .N (NUM_PORTS)
    ) u_arb (
        .Clk    (Clk),
        .Reset  (Reset),
        .req    (w_arb_req),
        .update (w_arb_update),
        .owner  (r_grant),
        .gnt    (w_arb_gnt)
    );

    // ------------------------------------------------------------------
    // Request of the arbitration winner
    // ------------------------------------------------------------------
    logic                   w_sel_read;
    logic [ADDR_W-1:0]      w_sel_addr;
    logic [BURST_W-1:0]     w_sel_burst_raw;
    logic [BURST_W-1:0]     w_sel_burst;
    logic [BE_W-1:0]        w_sel_be;
    op_t                    w_op;

    always_comb begin
        w_sel_read      = 1'b0;
        w_sel_addr      = '0;
        w_sel_burst_raw = '0;
        w_sel_be        = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (w_arb_gnt[p]) begin
                w_sel_read      = bus.req_read[p];
                w_sel_addr      = bus.req_addr[p*ADDR_W +: ADDR_W];
                w_sel_burst_raw = bus.req_burst[p*BURST_W +: BURST_W];
                w_sel_be        = bus.req_byteen[p*BE_W +: BE_W];
            end
        end
    end

    // A zero burst count means one word, which also keeps the down-counter
    // from ever starting at zero and wrapping.
    assign w_sel_burst = (w_sel_burst_raw == '0) ? BURST_W'(1) : w_sel_burst_raw;
    // Read has priority when a port raises both request bits.
    assign w_op        = w_sel_read ? OP_READ : OP_WRITE;

    // Write word of the granted port
    logic [DATA_W-1:0]      w_wr_sel_data;

    always_comb begin
        w_wr_sel_data = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_grant[p]) begin
                w_wr_sel_data = bus.wr_data[p*DATA_W +: DATA_W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Beat qualifiers
    // ------------------------------------------------------------------
    logic w_rd_phase;
    logic w_rd_beat;
    logic w_wr_accept;
    logic w_last;

    // Beats are counted from RD_CMD onwards, so a slave that returns data
    // in the command-accept cycle is still handled.
    assign w_rd_phase  = (r_state == RD_CMD) || (r_state == RD_DATA);
    assign w_rd_beat   = w_rd_phase && bus.avm_readdatavalid;
    assign w_wr_accept = (r_state == WR_BURST) && !bus.avm_waitrequest;
    assign w_last      = (r_cnt == BURST_W'(1));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (|w_arb_gnt) begin
                    w_state_nxt = (w_op == OP_READ) ? RD_CMD : WR_BURST;
                end
            end
            RD_CMD: begin
                if (w_rd_beat && w_last) begin
                    w_state_nxt = DONE;
                end else if (!bus.avm_waitrequest) begin
                    w_state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                if (w_rd_beat && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            WR_BURST: begin
                if (w_wr_accept && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_grant    <= '0;
            r_addr     <= '0;
            r_burst    <= '0;
            r_byteen   <= '0;
            r_cnt      <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= '0;
        end else begin
            r_rd_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (|w_arb_gnt) begin
                        r_grant  <= w_arb_gnt;
                        r_addr   <= w_sel_addr;
                        r_burst  <= w_sel_burst;
                        r_byteen <= w_sel_be;
                        r_cnt    <= w_sel_burst;
                    end
                end
                RD_CMD, RD_DATA: begin
                    if (w_rd_beat) begin
                        r_rd_data  <= bus.avm_readdata;
                        r_rd_valid <= r_grant;
                        r_cnt      <= r_cnt - BURST_W'(1);
                    end
                end
                WR_BURST: begin
                    if (w_wr_accept) begin
                        r_cnt <= r_cnt - BURST_W'(1);
                    end
                end
                DONE: begin
                    r_grant <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    logic w_cmd_rd;
    logic w_cmd_wr;
    logic w_cmd;

    assign w_cmd_rd = (r_state == RD_CMD);
    assign w_cmd_wr = (r_state == WR_BURST);
    assign w_cmd    = w_cmd_rd || w_cmd_wr;

    assign bus.avm_read       = w_cmd_rd;
    assign bus.avm_write      = w_cmd_wr;
    assign bus.avm_address    = w_cmd    ? r_addr        : '0;
    assign bus.avm_burstcount = w_cmd    ? r_burst       : '0;
    assign bus.avm_byteenable = w_cmd    ? r_byteen      : '0;
    assign bus.avm_writedata  = w_cmd_wr ? w_wr_sel_data : '0;

    assign bus.wr_data_ack    = w_wr_accept ? r_grant : '0;
    assign bus.done           = (r_state == DONE) ? r_grant : '0;
    assign bus.grant          = r_grant;
    assign bus.rd_data        = r_rd_data;
    assign bus.rd_valid       = r_rd_valid;

endmodule
`default_nettype wire

// File: doc/sdram_mp_burst_master.md
Name: sdram_mp_burst_master

Overview:
- Multi-port, burst-capable Avalon-MM master that lets NUM_PORTS FPGA-side clients share one SDRAM controller slave port.
- Round-robin arbitration between ports; one transaction of 1..MAX_BURST words at a time; per-port write-data flow control and read-data steering.
- Sits between the frame-buffer/CPU-side clients and the SDRAM controller. Supersedes the single-client, single-word master.

Parameters:
- NUM_PORTS, 2, number of client ports (2..8)
- ADDR_W, 25, word address width
- DATA_W, 32, data width (multiple of 8); BE_W = DATA_W/8 is a derived localparam
- BURST_W, 4, burst-count width; MAX_BURST = 2^BURST_W - 1

Ports:
- Clk  in  1  clock
- Reset  in  1  reset
- req_read  in  NUM_PORTS  per-port read request, level
- req_write  in  NUM_PORTS  per-port write request, level
- req_addr  in  NUM_PORTS*ADDR_W  start address, port i at [i*ADDR_W +: ADDR_W]
- req_burst  in  NUM_PORTS*BURST_W  word count; 0 is treated as 1
- req_byteen  in  NUM_PORTS*BE_W  byte enables, held for the whole burst
- wr_data  in  NUM_PORTS*DATA_W  current write word per port
- wr_data_ack  out  NUM_PORTS  write word accepted; client presents next word the following cycle
- rd_data  out  DATA_W  registered read word (shared by all ports)
- rd_valid  out  NUM_PORTS  one-hot; rd_data is valid for the flagged port
- grant  out  NUM_PORTS  one-hot owner of the current transaction
- done  out  NUM_PORTS  1-cycle pulse when the transaction completes
- avm_address  out  ADDR_W
- avm_read  out  1  active-high
- avm_write  out  1  active-high
- avm_burstcount  out  BURST_W
- avm_byteenable  out  BE_W
- avm_writedata  out  DATA_W
- avm_waitrequest  in  1
- avm_readdata  in  DATA_W
- avm_readdatavalid  in  1

Behaviour:
- Reset (Clk, Reset) is asynchronous and active-high.
- Reset value of every output is 0. Internal state: state=IDLE, last_grant=NUM_PORTS-1 (so port 0 has first priority), counters 0.
- Reset asserted mid-transaction aborts immediately; no done pulse is issued.
- FSM states: IDLE, RD_CMD, RD_DATA, WR_BURST, DONE.
- IDLE:
  - Port p is requesting if req_read[p] | req_write[p].
  - Pick the first requesting port searching last_grant+1, +2, ... (modulo NUM_PORTS).
  - Latch port, address, burst (0 -> 1), byteen and op. Read wins if both request bits of the chosen port are set.
  - grant asserts the next cycle and is held through DONE.
  - No requests: stay in IDLE.
- Latency: request sampled in cycle N; avm_read or avm_write asserts in N+1.
- RD_CMD:
  - avm_read=1; address, burstcount and byteenable come from latched values.
  - When avm_waitrequest=0, the command is accepted that cycle -> RD_DATA.
- Read data beats (counted in both RD_CMD and RD_DATA):
  - Each avm_readdatavalid loads rd_data and raises rd_valid[port] the next cycle, for 1 cycle per word.
  - The remaining-word counter decrements on each beat.
  - When the last word arrives -> DONE.
- WR_BURST:
  - avm_write=1, and avm_writedata = wr_data slice of the granted port (combinational).
  - address, burstcount and byteenable are held constant for the entire burst.
  - Each cycle with avm_waitrequest=0: wr_data_ack[port]=1 combinationally in that same cycle, and the counter decrements.
  - After the last accepted word -> DONE.
  - avm_write drops the cycle after the last accept.
- DONE:
  - done[port]=1 for 1 cycle; last_grant <= port; go to IDLE.
  - Requests are ignored in DONE. The client must drop its request by the cycle after done, otherwise it is re-arbitrated.
- Request inputs changing after the latch cycle have no effect on the in-flight transaction.
- avm_read and avm_write are never asserted together. The avm_* outputs are 0 outside RD_CMD and WR_BURST.
- Exactly one port is granted at any time; rd_valid, wr_data_ack and done only assert for the granted port.
- Counters are BURST_W bits wide; no wrap, because a burst count of 0 is mapped to 1.

Decomposition:
- Package sdram_mp_pkg holds:
  - the state enum (IDLE, RD_CMD, RD_DATA, WR_BURST, DONE)
  - the op typedef (OP_READ, OP_WRITE)
  - a localparam function for BE_W
- Sub-module rr_arbiter #(N):
  - inputs req[N] and update
  - output one-hot gnt[N]
  - holds the last_grant pointer register; the pointer advances only on update (pulsed in DONE).

Test Plan:
- Single read, NUM_PORTS=2: port0 reads addr 0x0000100, burst=1; slave waitrequest=1 for 2 cycles, readdatavalid 3 cycles later with 0xDEADBEEF -> avm_read held for 3 cycles, rd_valid[0] pulse with rd_data=0xDEADBEEF, then done[0].
- Write burst 4 with stalls: port1 writes 0x0000200, byteen=0xF; waitrequest toggles 1,0,1,0,0,0 -> exactly 4 wr_data_ack[1] pulses, each coinciding with waitrequest=0; avm_address and burstcount constant 0x200/4; then done[1].
- Fairness: both ports request continuously -> grants alternate 0,1,0,1.
- Fairness (port0 alone): port0 re-requests alone -> port0 is granted repeatedly.
- Burst 0 and read/write priority: port0 with req_burst=0, req_read=1, req_write=1 -> read of exactly 1 word, avm_burstcount=1, and no avm_write.
- Reset mid-burst: assert Reset during WR_BURST word 2 of 4 -> all outputs 0 immediately, no done pulse; after release, port0 is served first.
